// File: rtl/ahb_package.sv
// ahb_package: shared AHB-lite encodings, data-phase states and select helpers
package ahb_package;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;
  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_e;
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction
  function automatic logic is_onehot(input logic [15:0] v);
    return popcount(v) == 5'd1;
  endfunction
endpackage

// File: rtl/ahb_onehot_mux.sv
// ahb_onehot_mux: combinational one-hot payload selector, zero when nothing is selected
module ahb_onehot_mux #(
  parameter int CHANNEL_NUM = 4,
  parameter int PAYLOAD     = 34
) (
  input  logic [CHANNEL_NUM-1:0]              sel,
  input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] data,
  output logic [PAYLOAD-1:0]                  out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) out = out | (data[i] & {PAYLOAD{sel[i]}});
  end
endmodule

// File: rtl/ahb_dphase_resp_mux.sv
// ahb_dphase_resp_mux: registered AHB-lite data-phase response mux with a built-in
// default slave that answers bad decodes with a two-cycle ERROR and counts them
module ahb_dphase_resp_mux
  import ahb_package::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [CHANNEL_NUM-1:0]             hsel,
  input  logic [1:0]                         htrans,
  input  logic [CHANNEL_NUM-1:0][DATA_W-1:0] hrdata_in,
  input  logic [CHANNEL_NUM-1:0]             hreadyout_in,
  input  logic [CHANNEL_NUM-1:0]             hresp_in,
  output logic [DATA_W-1:0]                  hrdata_out,
  output logic                               hready_out,
  output logic                               hresp_out,
  input  logic                               clr_err,
  output logic [CNT_W-1:0]                   dec_err_cnt,
  output logic                               multi_hot_err
);
  logic [CHANNEL_NUM-1:0]             dsel_q;
  ds_state_e                          state;
  logic [CHANNEL_NUM-1:0][DATA_W+1:0] payload;
  logic [DATA_W+1:0]                  mux_out;
  logic [15:0]                        hsel_w;
  logic                               one, err_acc, multi_acc;
  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_pay
    assign payload[g] = {hrdata_in[g], hreadyout_in[g], hresp_in[g]};
  end
  ahb_onehot_mux #(.CHANNEL_NUM(CHANNEL_NUM), .PAYLOAD(DATA_W + 2)) u_mux (
    .sel  (dsel_q),
    .data (payload),
    .out  (mux_out)
  );
  // dsel_q == 0 means the default slave owns the data phase
  always_comb begin
    hrdata_out = |dsel_q ? mux_out[DATA_W+1:2] : '0;
    hready_out = |dsel_q ? mux_out[1] : (state != DS_ERR1);
    hresp_out  = |dsel_q ? mux_out[0] : ((state != DS_IDLE) ? ERROR : OKAY);
  end
  always_comb begin
    hsel_w    = 16'(hsel);
    one       = is_onehot(hsel_w);
    err_acc   = hready_out && htrans[1] && !one;
    multi_acc = err_acc && (popcount(hsel_w) >= 5'd2);
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q        <= '0;
      state         <= DS_IDLE;
      dec_err_cnt   <= '0;
      multi_hot_err <= 1'b0;
    end else begin
      if (hready_out) begin
        dsel_q <= (htrans[1] && one) ? hsel : '0;
        state  <= err_acc ? DS_ERR1 : DS_IDLE;
      end else if (state == DS_ERR1) begin
        state <= DS_ERR2;
      end
      if (clr_err) begin
        dec_err_cnt   <= '0;
        multi_hot_err <= 1'b0;
      end else begin
        if (err_acc && dec_err_cnt != '1) dec_err_cnt <= dec_err_cnt + 1'b1;
        if (multi_acc) multi_hot_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_dphase_resp_mux.sv
// tb_ahb_dphase_resp_mux: directed scoreboard bench for the data-phase response mux
module tb_ahb_dphase_resp_mux;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int CW = 2;
  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic [N-1:0]        hsel;
  logic [1:0]          htrans;
  logic [N-1:0][DW-1:0] hrdata_in;
  logic [N-1:0]        hreadyout_in;
  logic [N-1:0]        hresp_in;
  logic [DW-1:0]       hrdata_out;
  logic                hready_out;
  logic                hresp_out;
  logic                clr_err;
  logic [CW-1:0]       dec_err_cnt;
  logic                multi_hot_err;
  typedef struct {
    string         tag;
    logic [DW-1:0] d;
    logic          r;
    logic          s;
    logic [CW-1:0] c;
    logic          m;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  ahb_dphase_resp_mux #(.CHANNEL_NUM(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .hsel          (hsel),
    .htrans        (htrans),
    .hrdata_in     (hrdata_in),
    .hreadyout_in  (hreadyout_in),
    .hresp_in      (hresp_in),
    .hrdata_out    (hrdata_out),
    .hready_out    (hready_out),
    .hresp_out     (hresp_out),
    .clr_err       (clr_err),
    .dec_err_cnt   (dec_err_cnt),
    .multi_hot_err (multi_hot_err)
  );
  always #5 HCLK = ~HCLK;
  task automatic cyc(input string tag, input logic rn, input logic [N-1:0] sel, input logic [1:0] tr,
                     input logic [N-1:0] rdy, input logic [N-1:0] rsp, input logic clr,
                     input logic [DW-1:0] ed, input logic er, input logic es,
                     input logic [CW-1:0] ec, input logic em);
    exp_t e;
    @(negedge HCLK);
    HRESETn = rn;
    hsel = sel;
    htrans = tr;
    hreadyout_in = rdy;
    hresp_in = rsp;
    clr_err = clr;
    q.push_back('{tag, ed, er, es, ec, em});
    #1;
    e = q.pop_front();
    vectors++;
    assert (hrdata_out === e.d) else begin
      miscompares++;
      $error("FAIL %s hrdata_out got %h want %h", e.tag, hrdata_out, e.d);
    end
    assert (hready_out === e.r) else begin
      miscompares++;
      $error("FAIL %s hready_out got %b want %b", e.tag, hready_out, e.r);
    end
    assert (hresp_out === e.s) else begin
      miscompares++;
      $error("FAIL %s hresp_out got %b want %b", e.tag, hresp_out, e.s);
    end
    assert (dec_err_cnt === e.c) else begin
      miscompares++;
      $error("FAIL %s dec_err_cnt got %0d want %0d", e.tag, dec_err_cnt, e.c);
    end
    assert (multi_hot_err === e.m) else begin
      miscompares++;
      $error("FAIL %s multi_hot_err got %b want %b", e.tag, multi_hot_err, e.m);
    end
  endtask
  initial begin
    HRESETn = 1'b0;
    hsel = '0;
    htrans = 2'b00;
    hreadyout_in = '1;
    hresp_in = '0;
    clr_err = 1'b0;
    hrdata_in[0] = 32'h1111_0000;
    hrdata_in[1] = 32'h2222_0001;
    hrdata_in[2] = 32'hDEAD_BEEF;
    hrdata_in[3] = 32'h4444_0003;
    cyc("rst",       0, 4'b0100, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("rd_addr",   1, 4'b0100, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("rd_wait1",  1, 4'b0001, 2'b10, 4'b1011, 4'b0000, 0, 32'hDEAD_BEEF, 0, 0, 2'd0, 0);
    cyc("rd_wait2",  1, 4'b1000, 2'b10, 4'b1011, 4'b0000, 0, 32'hDEAD_BEEF, 0, 0, 2'd0, 0);
    cyc("rd_done",   1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'hDEAD_BEEF, 1, 0, 2'd0, 0);
    cyc("um_addr",   1, 4'b0000, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("um_err1",   1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd1, 0);
    cyc("um_err2",   1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 1, 2'd1, 0);
    cyc("mh_addr",   1, 4'b0011, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd1, 0);
    cyc("mh_err1",   1, 4'b0000, 2'b11, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd2, 1);
    cyc("mh_err2",   1, 4'b0000, 2'b11, 4'b1111, 4'b0000, 0, 32'h0,         1, 1, 2'd2, 1);
    cyc("b2b_err1",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd3, 1);
    cyc("b2b_err2",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 1, 2'd3, 1);
    cyc("idle_unm",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd3, 1);
    cyc("busy_unm",  1, 4'b0000, 2'b01, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd3, 1);
    cyc("sat_addr",  1, 4'b0000, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd3, 1);
    cyc("sat_err1",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd3, 1);
    cyc("sat_err2",  1, 4'b1100, 2'b10, 4'b1111, 4'b0000, 1, 32'h0,         1, 1, 2'd3, 1);
    cyc("clr_err1",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd0, 0);
    cyc("clr_err2",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 1, 2'd0, 0);
    cyc("sl_addr",   1, 4'b0010, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("sl_err",    1, 4'b0000, 2'b00, 4'b1111, 4'b0010, 0, 32'h2222_0001, 1, 1, 2'd0, 0);
    cyc("sl_nocnt",  1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("r_addr",    1, 4'b0101, 2'b10, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("r_err1",    1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         0, 1, 2'd1, 1);
    cyc("r_async",   0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("r_after",   1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    cyc("r_idle",    1, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 32'h0,         1, 0, 2'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
